udp_report_framer: RTL and testbench
====================================

Name: udp_report_framer

Overview:
- Egress counterpart of the UDP order-ingress path. Collects 32-bit report words (trade executions from the matching engine, book-dump entries) into a word FIFO and serialises them into framed byte-stream payloads.
- Payload format mirrors the ingress format: 3-byte opcode, then big-endian 32-bit words, with tlast on the final byte.
- Sits between the engine/order-book outputs and the UDP TX FIFO (tx_fifo_tdata/tvalid/tready) in the engine clock domain.

Parameters:
- MAX_WORDS, 16, maximum report words per frame (1..255).
- FIFO_DEPTH, 32, word FIFO depth (power of two, >= MAX_WORDS).
- IDLE_TIMEOUT, 256, cycles a partial batch may wait before being sent.
- OP_TRADE, 24'hA0B0C0, opcode for trade-report frames.
- OP_DUMP, 24'hF0E0D0, opcode for dump-response frames (same value as the dump request).

Ports:
- clk_engine  in  1  engine clock; all logic on its rising edge.
- rst_engine  in  1  synchronous, active-high reset.
- in_word  in  32  report word ({price[31:16], is_buy[15], is_bot[14], qty[13:0]}).
- in_is_dump  in  1  word kind: 1 = dump entry, 0 = trade report.
- in_valid  in  1  word-strobe valid.
- in_ready  out  1  high when the FIFO is not full.
- flush  in  1  single-cycle request to send all buffered words now (end of dump).
- tx_tdata  out  8  payload byte.
- tx_tvalid  out  1  byte valid.
- tx_tready  in  1  downstream accept.
- tx_tlast  out  1  last byte of frame.
- busy  out  1  high when state is not IDLE.
- frames_sent  out  16  count of completed frames; wraps at 65535 -> 0.

Behaviour:
- Reset values (all synchronous): tx_tvalid=0, tx_tlast=0, tx_tdata=0, busy=0, frames_sent=0; FIFO, flush_pending and the timeout counter cleared. in_ready=1 in the cycle after reset.
- Reset mid-frame: tx_tvalid drops in the next cycle. The frame is truncated without tlast and the buffered words are discarded.
- Input handshake: a word is accepted when in_valid && in_ready. Each FIFO entry is 33 bits {in_is_dump, in_word}. If in_valid is asserted while the FIFO is full, the word is dropped and in_ready stays 0.
- flush sets flush_pending. If the FIFO is empty at the flush pulse, flush_pending is cleared and no frame is sent (no empty frames).
- Idle timer: counts while in IDLE with a non-empty FIFO. It is zeroed on each word accept and when leaving IDLE. It expires when it reaches IDLE_TIMEOUT-1.
- FSM states: IDLE, HDR, PAYLOAD.
  - IDLE -> HDR when the FIFO is non-empty and any of: count >= MAX_WORDS, flush_pending, or timer expired. The opcode is latched from the head entry's kind bit.
  - tx_tvalid rises 1 cycle after the start condition is seen.
  - HDR sends 3 opcode bytes, MSB first, each advanced on tvalid&&tready.
  - PAYLOAD pops the head word and sends bytes [31:24], [23:16], [15:8], [7:0].
- tx_tlast is set on byte [7:0] when any of the following holds:
  - words_in_frame == MAX_WORDS;
  - the FIFO is empty in that cycle;
  - the next head word's kind differs from the latched kind.
  Otherwise the next word is popped with no bubble.
- A word arriving in the same cycle as the tlast decision does not extend the frame.
- AXIS rules: tdata and tlast are stable while tvalid && !tready. There is no combinational path from tready to tvalid. Throughput is 1 byte/cycle under continuous tready.
- On the tlast beat accept: frames_sent increments and the FSM returns to IDLE.
  - flush_pending is cleared if the FIFO is empty at that point.
  - Otherwise flush_pending persists and the next frame starts immediately.
- A flush arriving during a frame stays pending and is served after it.
- The FIFO accepts input during framing. A push and a pop in the same cycle leave count unchanged.

Optional Feature:
- Macro FRAMER_SEQ_NUM_EN.
- When defined: HDR emits 5 bytes: the opcode followed by frames_sent[15:8], frames_sent[7:0] (the pre-increment value), so the receiver can detect lost frames.
- When undefined: HDR emits 3 bytes and the sequence logic is absent. frames_sent still counts.

Decomposition:
- Shared package: opcode constants (OP_MARKET, OP_DUMP, OP_TRADE), order-word field offsets, FSM state encoding.
- One sub-module: framer_word_fifo.
  - Synchronous FIFO, 33-bit wide, FIFO_DEPTH entries.
  - Outputs: count, full, empty, and head data with first-word fall-through.

Test Plan:
- 1 trade word 0x0069400A, no flush, tready=1 -> after IDLE_TIMEOUT cycles, bytes A0 B0 C0 00 69 40 0A with tlast on 0A; frames_sent=1.
- 20 trade words back-to-back -> frame 1 carries exactly 16 words (67 bytes, tlast on byte 67). The remaining 4 words go out after the timeout; frames_sent=2.
- 5 dump words, then flush -> one F0E0D0 frame of 23 bytes, sent without waiting for the timeout.
- 2 trade words followed by 2 dump words, then flush -> A0B0C0 frame of 2 words, then F0E0D0 frame of 2 words.
- Random tready stalls (30% low) on a 16-word frame -> byte sequence identical to the no-stall case, and tdata stable whenever a stall occurs.
- Assert rst_engine mid-PAYLOAD -> tx_tvalid=0 the next cycle, FIFO empty, frames_sent=0. With FRAMER_SEQ_NUM_EN defined, the next frame's sequence bytes are 00 00.

Source files
------------

// File: rtl/udp_report_framer_pkg.sv
// ---------------------------------------------------------------------------
// udp_report_framer_pkg
// Shared constants for the UDP report egress path: frame opcodes (they mirror
// the ingress opcodes), field offsets of a 32-bit order/report word, and the
// framer FSM state encoding.
// ---------------------------------------------------------------------------
package udp_report_framer_pkg;

    // Frame opcodes (first three payload bytes, MSB first)
    localparam logic [23:0] OP_MARKET = 24'hA5B5C5;  // ingress market-order frame
    localparam logic [23:0] OP_DUMP   = 24'hF0E0D0;  // dump request / dump response
    localparam logic [23:0] OP_TRADE  = 24'hA0B0C0;  // trade-report frame

    // Report word layout: {price[31:16], is_buy[15], is_bot[14], qty[13:0]}
    localparam int PRICE_LSB  = 16;
    localparam int PRICE_W    = 16;
    localparam int IS_BUY_BIT = 15;
    localparam int IS_BOT_BIT = 14;
    localparam int QTY_LSB    = 0;
    localparam int QTY_W      = 14;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

endpackage

// File: rtl/udp_report_framer_word_fifo.sv
// ---------------------------------------------------------------------------
// framer_word_fifo
// Synchronous first-word-fall-through FIFO for {is_dump, word} entries.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_push, i_data    write strobe / entry (ignored while full)
//   i_pop             read strobe (ignored while empty)
//   o_head            entry at the head, valid whenever !o_empty
//   o_count           number of stored entries
//   o_full, o_empty   status flags
// ---------------------------------------------------------------------------
module framer_word_fifo #(
    parameter int DEPTH = 32,   // power of two
    parameter int W     = 33
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int              AW       = $clog2(DEPTH);
    localparam int              CNTW     = AW + 1;
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    logic [W-1:0]    r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CNTW-1:0] r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // storage carries no reset; only pointers/count define contents
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/udp_report_framer.sv
// ---------------------------------------------------------------------------
// udp_report_framer
// Buffers 32-bit report words and emits framed byte payloads:
//   opcode (3 bytes, MSB first) [+ seq hi, seq lo] then big-endian words,
//   tlast on the final byte. A frame holds words of a single kind only.
// Optional build macro FRAMER_SEQ_NUM_EN: header gains frames_sent[15:8],
// frames_sent[7:0] after the opcode.
// Ports:
//   clk_engine, rst_engine   clock, synchronous active-high reset
//   in_word/in_is_dump/in_valid/in_ready   report word input handshake
//   flush                    send everything buffered now
//   tx_tdata/tvalid/tready/tlast           byte stream to the UDP TX FIFO
//   busy                     FSM not idle
//   frames_sent              completed frames, wrapping
// ---------------------------------------------------------------------------
module udp_report_framer
    import udp_report_framer_pkg::*;
#(
    parameter int          MAX_WORDS    = 16,
    parameter int          FIFO_DEPTH   = 32,
    parameter int          IDLE_TIMEOUT = 256,
    parameter logic [23:0] OP_TRADE     = udp_report_framer_pkg::OP_TRADE,
    parameter logic [23:0] OP_DUMP      = udp_report_framer_pkg::OP_DUMP
) (
    input  logic        clk_engine,
    input  logic        rst_engine,
    input  logic [31:0] in_word,
    input  logic        in_is_dump,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [7:0]  tx_tdata,
    output logic        tx_tvalid,
    input  logic        tx_tready,
    output logic        tx_tlast,
    output logic        busy,
    output logic [15:0] frames_sent
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(IDLE_TIMEOUT) + 1;
`ifdef FRAMER_SEQ_NUM_EN
    localparam logic [2:0] HDR_LAST = 3'd4;
`else
    localparam logic [2:0] HDR_LAST = 3'd2;
`endif
    localparam logic [CW-1:0] MAXW_C   = CW'(MAX_WORDS);
    localparam logic [7:0]    MAXW_F   = 8'(MAX_WORDS);
    localparam logic [TW-1:0] TMO_LAST = TW'(IDLE_TIMEOUT - 1);

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_tdata, w_tdata_nxt;
    logic          r_tvalid, w_tvalid_nxt;
    logic          r_tlast, w_tlast_nxt;
    logic [2:0]    r_idx, w_idx_nxt;
    logic [31:0]   r_word, w_word_nxt;
    logic [7:0]    r_words, w_words_nxt;
    logic          r_kind, w_kind_nxt;
    logic          r_flush;
    logic [TW-1:0] r_timer;
    logic [15:0]   r_frames;

    logic          w_push, w_pop, w_full, w_empty, w_acc, w_tmo, w_start, w_done;
    logic [CW-1:0] w_count;
    logic [32:0]   w_head;

    framer_word_fifo #(.DEPTH(FIFO_DEPTH), .W(33)) u_fifo (
        .clk     (clk_engine),
        .rst     (rst_engine),
        .i_push  (in_valid),
        .i_data  ({in_is_dump, in_word}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;
    assign w_acc    = r_tvalid && tx_tready;
    assign w_tmo    = (r_timer == TMO_LAST);
    assign w_start  = !w_empty && ((w_count >= MAXW_C) || r_flush || w_tmo);

    function automatic logic [7:0] hdr_byte(input logic kind, input logic [2:0] idx);
        logic [23:0] op;
        op = kind ? OP_DUMP : OP_TRADE;
        case (idx)
            3'd0:    hdr_byte = op[23:16];
            3'd1:    hdr_byte = op[15:8];
`ifdef FRAMER_SEQ_NUM_EN
            3'd3:    hdr_byte = r_frames[15:8];
            3'd4:    hdr_byte = r_frames[7:0];
`endif
            default: hdr_byte = op[7:0];
        endcase
    endfunction

    // Output byte register is reloaded only on an accept, so tdata/tlast hold
    // through stalls and tvalid never depends combinationally on tready.
    always_comb begin
        w_state_nxt  = r_state;
        w_tdata_nxt  = r_tdata;
        w_tvalid_nxt = r_tvalid;
        w_tlast_nxt  = r_tlast;
        w_idx_nxt    = r_idx;
        w_word_nxt   = r_word;
        w_words_nxt  = r_words;
        w_kind_nxt   = r_kind;
        w_pop        = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: if (w_start) begin
                w_state_nxt  = ST_HDR;
                w_kind_nxt   = w_head[32];
                w_idx_nxt    = 3'd0;
                w_tdata_nxt  = hdr_byte(w_head[32], 3'd0);
                w_tvalid_nxt = 1'b1;
                w_tlast_nxt  = 1'b0;
            end
            ST_HDR: if (w_acc) begin
                if (r_idx == HDR_LAST) begin
                    w_pop       = 1'b1;
                    w_word_nxt  = w_head[31:0];
                    w_tdata_nxt = w_head[31:24];
                    w_idx_nxt   = 3'd0;
                    w_words_nxt = 8'd1;
                    w_state_nxt = ST_PAYLOAD;
                end else begin
                    w_idx_nxt   = r_idx + 3'd1;
                    w_tdata_nxt = hdr_byte(r_kind, r_idx + 3'd1);
                end
            end
            ST_PAYLOAD: if (w_acc) begin
                w_idx_nxt = r_idx + 3'd1;
                case (r_idx)
                    3'd0: w_tdata_nxt = r_word[23:16];
                    3'd1: w_tdata_nxt = r_word[15:8];
                    3'd2: begin
                        // decided on registered FIFO state: a word pushed
                        // this cycle cannot extend the frame
                        w_tdata_nxt = r_word[7:0];
                        w_tlast_nxt = (r_words == MAXW_F) || w_empty ||
                                      (w_head[32] != r_kind);
                    end
                    default: begin
                        if (r_tlast) begin
                            w_done       = 1'b1;
                            w_tvalid_nxt = 1'b0;
                            w_tlast_nxt  = 1'b0;
                            w_state_nxt  = ST_IDLE;
                        end else begin
                            w_pop       = 1'b1;
                            w_word_nxt  = w_head[31:0];
                            w_tdata_nxt = w_head[31:24];
                            w_idx_nxt   = 3'd0;
                            w_words_nxt = r_words + 8'd1;
                        end
                    end
                endcase
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_engine) begin
        if (rst_engine) begin
            r_state  <= ST_IDLE;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_idx    <= '0;
            r_word   <= '0;
            r_words  <= '0;
            r_kind   <= 1'b0;
            r_flush  <= 1'b0;
            r_timer  <= '0;
            r_frames <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_tdata  <= w_tdata_nxt;
            r_tvalid <= w_tvalid_nxt;
            r_tlast  <= w_tlast_nxt;
            r_idx    <= w_idx_nxt;
            r_word   <= w_word_nxt;
            r_words  <= w_words_nxt;
            r_kind   <= w_kind_nxt;
            if (w_done) r_frames <= r_frames + 16'd1;
            // a flush with nothing buffered is dropped; otherwise it stays
            // pending across frames until the FIFO drains
            if (flush)
                r_flush <= !w_empty;
            else if (w_done && w_empty)
                r_flush <= 1'b0;
            if (r_state != ST_IDLE || w_empty || w_push)
                r_timer <= '0;
            else if (!w_tmo)
                r_timer <= r_timer + TW'(1);
        end
    end

    assign tx_tdata    = r_tdata;
    assign tx_tvalid   = r_tvalid;
    assign tx_tlast    = r_tlast;
    assign busy        = (r_state != ST_IDLE);
    assign frames_sent = r_frames;

endmodule

// File: tb/tb_udp_report_framer.sv
module tb_udp_report_framer;
    logic        clk_engine = 1'b0;
    logic        rst_engine = 1'b1;
    logic [31:0] in_word    = '0;
    logic        in_is_dump = 1'b0;
    logic        in_valid   = 1'b0;
    logic        in_ready;
    logic        flush      = 1'b0;
    logic [7:0]  tx_tdata;
    logic        tx_tvalid;
    logic        tx_tready  = 1'b1;
    logic        tx_tlast;
    logic        busy;
    logic [15:0] frames_sent;

    int          n_vec = 0;
    int          n_err = 0;
    logic        stall_en = 1'b0;
    logic [8:0]  cap_q[$];   // {tlast, tdata} of every accepted byte
    logic [8:0]  exp_q[$];
    logic [15:0] exp_fs = '0;
    logic        p_stall = 1'b0;
    logic [7:0]  p_d = '0;
    logic        p_l = 1'b0;

    udp_report_framer dut (
        .clk_engine  (clk_engine),
        .rst_engine  (rst_engine),
        .in_word     (in_word),
        .in_is_dump  (in_is_dump),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .tx_tdata    (tx_tdata),
        .tx_tvalid   (tx_tvalid),
        .tx_tready   (tx_tready),
        .tx_tlast    (tx_tlast),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    always #5 clk_engine = ~clk_engine;

    always @(posedge clk_engine) begin
        #1;
        tx_tready = stall_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // byte capture and stall-stability watch, sampled mid-cycle
    always @(negedge clk_engine) begin
        if (stall_en && p_stall) begin
            n_vec++;
            if (!(tx_tvalid && tx_tdata == p_d && tx_tlast == p_l)) begin
                n_err++;
                $display("FAIL stall hold: got v%0b d%0h l%0b, expected v1 d%0h l%0b",
                         tx_tvalid, tx_tdata, tx_tlast, p_d, p_l);
            end
        end
        p_stall = tx_tvalid && !tx_tready && !rst_engine;
        p_d     = tx_tdata;
        p_l     = tx_tlast;
        if (!rst_engine && tx_tvalid && tx_tready) cap_q.push_back({tx_tlast, tx_tdata});
    end

    typedef struct {
        logic [31:0] word;
        logic        dump;
        logic [55:0] exp_bytes;   // opcode then payload, as seen on the wire
    } vec_t;

    task automatic push(input logic [31:0] w, input logic d);
        in_word = w; in_is_dump = d; in_valid = 1'b1;
        @(posedge clk_engine); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk_engine); #1;
        flush = 1'b0;
    endtask

    task automatic begin_frame(input logic [23:0] op);
        exp_q.delete();
        exp_q.push_back({1'b0, op[23:16]});
        exp_q.push_back({1'b0, op[15:8]});
        exp_q.push_back({1'b0, op[7:0]});
`ifdef FRAMER_SEQ_NUM_EN
        exp_q.push_back({1'b0, exp_fs[15:8]});
        exp_q.push_back({1'b0, exp_fs[7:0]});
`endif
    endtask

    task automatic add_word(input logic [31:0] w);
        exp_q.push_back({1'b0, w[31:24]});
        exp_q.push_back({1'b0, w[23:16]});
        exp_q.push_back({1'b0, w[15:8]});
        exp_q.push_back({1'b0, w[7:0]});
    endtask

    task automatic expect_frame(input string nm, input int budget);
        int cyc = 0;
        logic [8:0] got;
        exp_q[exp_q.size()-1][8] = 1'b1;
        while (cap_q.size() < exp_q.size() && cyc < budget) begin
            @(negedge clk_engine);
            cyc++;
        end
        if (cap_q.size() < exp_q.size()) begin
            n_vec++; n_err++;
            $display("FAIL %s timeout: got %0d bytes, expected %0d", nm, cap_q.size(), exp_q.size());
            cap_q.delete();
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                got = cap_q.pop_front();
                chk($sformatf("%s byte%0d", nm, i), {23'b0, got}, {23'b0, exp_q[i]});
            end
        end
        exp_fs++;
        @(posedge clk_engine); #1;
    endtask

    initial begin
        vec_t vt[4];
        logic early;
        int   cyc;
        logic [31:0] w20[20];

        vt[0] = '{32'h0069400A, 1'b0, 56'hA0B0C0_0069400A};
        vt[1] = '{32'h12345678, 1'b1, 56'hF0E0D0_12345678};
        vt[2] = '{32'hFFFF7FFF, 1'b0, 56'hA0B0C0_FFFF7FFF};
        vt[3] = '{32'h00000000, 1'b1, 56'hF0E0D0_00000000};
        for (int i = 0; i < 20; i++) w20[i] = 32'h11000000 + i * 32'h00010203;

        // reset state
        repeat (3) @(posedge clk_engine);
        #1;
        chk("rst tvalid", {31'b0, tx_tvalid}, 0);
        chk("rst tlast", {31'b0, tx_tlast}, 0);
        chk("rst tdata", {24'b0, tx_tdata}, 0);
        chk("rst busy", {31'b0, busy}, 0);
        chk("rst frames", {16'b0, frames_sent}, 0);
        rst_engine = 1'b0;
        @(posedge clk_engine); #1;
        chk("in_ready after rst", {31'b0, in_ready}, 1);

        // single word, released only by the idle timer
        push(32'h0069400A, 1'b0);
        early = 1'b0;
        repeat (250) begin
            @(negedge clk_engine);
            if (tx_tvalid) early = 1'b1;
        end
        @(posedge clk_engine); #1;
        chk("no send before timeout", {31'b0, early}, 0);
        begin_frame(24'hA0B0C0); add_word(32'h0069400A);
        expect_frame("timeout", 40);
        chk("frames after timeout", {16'b0, frames_sent}, 1);

        // table: one word then flush
        for (int v = 0; v < 4; v++) begin
            push(vt[v].word, vt[v].dump);
            do_flush();
            begin_frame(vt[v].exp_bytes[55:32]);
            add_word(vt[v].exp_bytes[31:0]);
            expect_frame($sformatf("vec%0d", v), 30);
            chk($sformatf("vec%0d frames", v), {16'b0, frames_sent}, {16'b0, exp_fs});
        end

        // 20 words: full 16-word frame, remainder on timeout
        for (int i = 0; i < 20; i++) push(w20[i], 1'b0);
        begin_frame(24'hA0B0C0);
        for (int i = 0; i < 16; i++) add_word(w20[i]);
        expect_frame("max frame", 200);
        begin_frame(24'hA0B0C0);
        for (int i = 16; i < 20; i++) add_word(w20[i]);
        expect_frame("tail frame", 400);
        chk("frames after 20", {16'b0, frames_sent}, {16'b0, exp_fs});

        // 5 dump words + flush, well inside the timeout
        for (int i = 0; i < 5; i++) push(32'hD0000000 + i, 1'b1);
        do_flush();
        begin_frame(24'hF0E0D0);
        for (int i = 0; i < 5; i++) add_word(32'hD0000000 + i);
        expect_frame("dump5", 40);

        // kind change splits the batch; pending flush serves both frames
        push(32'hAAAA0001, 1'b0); push(32'hAAAA0002, 1'b0);
        push(32'hBBBB0001, 1'b1); push(32'hBBBB0002, 1'b1);
        do_flush();
        begin_frame(24'hA0B0C0); add_word(32'hAAAA0001); add_word(32'hAAAA0002);
        expect_frame("mix trade", 30);
        begin_frame(24'hF0E0D0); add_word(32'hBBBB0001); add_word(32'hBBBB0002);
        expect_frame("mix dump", 30);
        chk("frames after mix", {16'b0, frames_sent}, {16'b0, exp_fs});

        // random backpressure on a 16-word frame
        stall_en = 1'b1;
        for (int i = 0; i < 16; i++) push(w20[i] ^ 32'h5A5A5A5A, 1'b0);
        begin_frame(24'hA0B0C0);
        for (int i = 0; i < 16; i++) add_word(w20[i] ^ 32'h5A5A5A5A);
        expect_frame("stall frame", 400);
        stall_en = 1'b0;
        chk("frames after stall", {16'b0, frames_sent}, {16'b0, exp_fs});

        // reset in the middle of a payload
        for (int i = 0; i < 16; i++) push(w20[i], 1'b0);
        cyc = 0;
        while (cap_q.size() < 6 && cyc < 100) begin
            @(negedge clk_engine);
            cyc++;
        end
        chk("reached payload", {31'b0, (cap_q.size() >= 6)}, 1);
        @(posedge clk_engine); #1;
        rst_engine = 1'b1;
        @(posedge clk_engine); #1;
        chk("midrst tvalid", {31'b0, tx_tvalid}, 0);
        chk("midrst busy", {31'b0, busy}, 0);
        chk("midrst frames", {16'b0, frames_sent}, 0);
        rst_engine = 1'b0;
        cap_q.delete();
        exp_fs = '0;
        @(posedge clk_engine); #1;
        chk("midrst in_ready", {31'b0, in_ready}, 1);
        do_flush();
        repeat (300) @(posedge clk_engine);
        #1;
        chk("fifo empty after rst", cap_q.size(), 0);
        push(32'h0BADF00D, 1'b0);
        do_flush();
        begin_frame(24'hA0B0C0); add_word(32'h0BADF00D);
        expect_frame("post rst", 30);
        chk("frames post rst", {16'b0, frames_sent}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
